// File: rtl/dec_cmd_sched.sv
// Command scheduler in front of the decision-tree core: packs host commands, tags
// classify requests with IDs, bounds in-flight work and watches for hung requests.
module dec_cmd_sched #(
  parameter int NUM_FEATURE = 8,
  parameter int MAX_OUT     = 15,
  parameter int TIMEOUT     = 1023,
  parameter int ID_W        = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [8:0]               cmd_addr,
  input  logic [7:0]               cmd_wdata,
  input  logic [8*NUM_FEATURE-1:0] cmd_feat,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [1:0]               dec_mode,
  output logic [8*NUM_FEATURE-1:0] dec_data,
  output logic [ID_W-1:0]          dec_id,
  input  logic                     res_valid,
  input  logic [ID_W-1:0]          res_id,
  input  logic                     res_class,
  output logic                     rslt_valid,
  output logic [ID_W-1:0]          rslt_id,
  output logic                     rslt_class,
  output logic                     busy,
  output logic                     err_timeout,
  output logic [15:0]              cls_count
);

  localparam int DATA_W  = 8 * NUM_FEATURE;
  localparam int OUT_W   = $clog2(MAX_OUT + 1);
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  localparam logic [OUT_W-1:0]   MAX_OUT_C = OUT_W'(MAX_OUT);
  localparam logic [STALL_W-1:0] TIMEOUT_C = STALL_W'(TIMEOUT);
  localparam logic [1:0]         OP_CLASSIFY = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic              hold_v_q, hold_v_d;
  logic [1:0]        hold_op_q, hold_op_d;
  logic [8:0]        hold_addr_q, hold_addr_d;
  logic [7:0]        hold_wdata_q, hold_wdata_d;
  logic [DATA_W-1:0] hold_feat_q, hold_feat_d;

  logic [ID_W-1:0]    next_id_q, next_id_d;
  logic [15:0]        cls_count_q, cls_count_d;
  logic [OUT_W-1:0]   outstanding_q, outstanding_d;
  logic [1:0]         state_q, state_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_q, err_d;
  logic               rslt_valid_q, rslt_valid_d;
  logic [ID_W-1:0]    rslt_id_q, rslt_id_d;
  logic               rslt_class_q, rslt_class_d;

  logic is_cls;
  logic issue_ok;
  logic fire;
  logic accept;
  logic cls_fire;
  logic retire;

  // Writes must not reach the tables while any classification could still read them.
  always_comb begin
    is_cls   = (hold_op_q == OP_CLASSIFY);
    issue_ok = 1'b0;
    if (is_cls) begin
      issue_ok = (outstanding_q < MAX_OUT_C) && (state_q != ST_DRAIN);
    end else begin
      issue_ok = (outstanding_q == '0) && !res_valid;
    end
  end

  assign dec_valid = hold_v_q & issue_ok;
  assign fire      = dec_valid & dec_ready;
  assign cmd_ready = ~hold_v_q | fire;
  assign accept    = cmd_valid & cmd_ready;
  assign cls_fire  = fire & is_cls;
  assign retire    = res_valid & (outstanding_q != '0);

  always_comb begin
    dec_mode = hold_op_q;
    dec_data = '0;
    dec_id   = '0;
    if (is_cls) begin
      dec_data = hold_feat_q;
      dec_id   = next_id_q;
    end else begin
      dec_data[7:0]   = hold_wdata_q;
      dec_data[15:8]  = hold_addr_q[7:0];
      dec_data[23:16] = {7'b0, hold_addr_q[8]};
    end
  end

  always_comb begin
    hold_v_d     = hold_v_q;
    hold_op_d    = hold_op_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_feat_d  = hold_feat_q;
    if (accept) begin
      hold_v_d     = 1'b1;
      hold_op_d    = cmd_op;
      hold_addr_d  = cmd_addr;
      hold_wdata_d = cmd_wdata;
      hold_feat_d  = cmd_feat;
    end else if (fire) begin
      hold_v_d = 1'b0;
    end
  end

  // A retire that arrives in the same cycle as a new issue leaves the count unchanged.
  always_comb begin
    next_id_d     = next_id_q;
    cls_count_d   = cls_count_q;
    outstanding_d = outstanding_q;
    if (cls_fire) begin
      next_id_d   = next_id_q + ID_W'(1);
      cls_count_d = cls_count_q + 16'd1;
    end
    case ({cls_fire, retire})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cls_fire) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (outstanding_d == '0) begin
          state_d = ST_IDLE;
        end else if (hold_v_q && !is_cls) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outstanding_d == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The stall counter saturates so the sticky flag cannot be missed by wrapping.
  always_comb begin
    stall_d = stall_q;
    if ((outstanding_q == '0) || res_valid) begin
      stall_d = '0;
    end else if (stall_q != TIMEOUT_C) begin
      stall_d = stall_q + STALL_W'(1);
    end
    err_d = err_q | (stall_q == TIMEOUT_C);
  end

  always_comb begin
    rslt_valid_d = res_valid;
    rslt_id_d    = res_id;
    rslt_class_d = res_class;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v_q      <= 1'b0;
      hold_op_q     <= '0;
      hold_addr_q   <= '0;
      hold_wdata_q  <= '0;
      hold_feat_q   <= '0;
      next_id_q     <= '0;
      cls_count_q   <= '0;
      outstanding_q <= '0;
      state_q       <= ST_IDLE;
      stall_q       <= '0;
      err_q         <= 1'b0;
      rslt_valid_q  <= 1'b0;
      rslt_id_q     <= '0;
      rslt_class_q  <= 1'b0;
    end else begin
      hold_v_q      <= hold_v_d;
      hold_op_q     <= hold_op_d;
      hold_addr_q   <= hold_addr_d;
      hold_wdata_q  <= hold_wdata_d;
      hold_feat_q   <= hold_feat_d;
      next_id_q     <= next_id_d;
      cls_count_q   <= cls_count_d;
      outstanding_q <= outstanding_d;
      state_q       <= state_d;
      stall_q       <= stall_d;
      err_q         <= err_d;
      rslt_valid_q  <= rslt_valid_d;
      rslt_id_q     <= rslt_id_d;
      rslt_class_q  <= rslt_class_d;
    end
  end

  assign rslt_valid  = rslt_valid_q;
  assign rslt_id     = rslt_id_q;
  assign rslt_class  = rslt_class_q;
  assign busy        = hold_v_q | (outstanding_q != '0);
  assign err_timeout = err_q;
  assign cls_count   = cls_count_q;

endmodule

// File: tb/tb_dec_cmd_sched.sv
// Bench for dec_cmd_sched: directed scenarios plus random traffic, every cycle checked
// against a transaction-level model (pending-ID list, counters, idle-run watchdog).
module tb_dec_cmd_sched;

  localparam int TB_TIMEOUT = 7;
  localparam int TB_MAX_OUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [8:0]  cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic [63:0] cmd_feat = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [1:0]  dec_mode;
  logic [63:0] dec_data;
  logic [11:0] dec_id;
  logic        res_valid = 1'b0;
  logic [11:0] res_id = '0;
  logic        res_class = 1'b0;
  logic        rslt_valid;
  logic [11:0] rslt_id;
  logic        rslt_class;
  logic        busy;
  logic        err_timeout;
  logic [15:0] cls_count;

  dec_cmd_sched #(
    .NUM_FEATURE(8),
    .MAX_OUT(TB_MAX_OUT),
    .TIMEOUT(TB_TIMEOUT),
    .ID_W(12)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_feat(cmd_feat),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_mode(dec_mode),
    .dec_data(dec_data), .dec_id(dec_id),
    .res_valid(res_valid), .res_id(res_id), .res_class(res_class),
    .rslt_valid(rslt_valid), .rslt_id(rslt_id), .rslt_class(rslt_class),
    .busy(busy), .err_timeout(err_timeout), .cls_count(cls_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit          m_hold_v;
  logic [1:0]  m_op;
  logic [8:0]  m_addr;
  logic [7:0]  m_wdata;
  logic [63:0] m_feat;
  int          m_pending[$];
  int          m_next_id;
  int          m_cls;
  bit          m_err;
  int          m_run;
  bit          m_rv;
  int          m_rid;
  bit          m_rcls;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      $error("[TB] %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_hold_v  = 1'b0;
    m_op      = '0;
    m_addr    = '0;
    m_wdata   = '0;
    m_feat    = '0;
    m_pending.delete();
    m_next_id = 0;
    m_cls     = 0;
    m_err     = 1'b0;
    m_run     = 0;
    m_rv      = 1'b0;
    m_rid     = 0;
    m_rcls    = 1'b0;
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_feat  = '0;
    dec_ready = 1'b0;
    res_valid = 1'b0;
    res_id    = '0;
    res_class = 1'b0;
    #2;
    modelReset();
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rst_dec_valid", 64'(dec_valid), 64'd0);
    checkOutput("rst_dec_mode", 64'(dec_mode), 64'd0);
    checkOutput("rst_dec_data", dec_data, 64'd0);
    checkOutput("rst_dec_id", 64'(dec_id), 64'd0);
    checkOutput("rst_rslt_valid", 64'(rslt_valid), 64'd0);
    checkOutput("rst_rslt_id", 64'(rslt_id), 64'd0);
    checkOutput("rst_rslt_class", 64'(rslt_class), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_err", 64'(err_timeout), 64'd0);
    checkOutput("rst_cls_count", 64'(cls_count), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive, check every output against the model, advance the model.
  task automatic applyStimulus(input bit cv, input logic [1:0] op, input logic [8:0] addr,
                               input logic [7:0] wdata, input logic [63:0] feat, input bit drdy,
                               input bit rv, input int rid, input bit rcls);
    bit          exp_ok, exp_dv, exp_fire, exp_rdy;
    logic [63:0] exp_data;
    int          pre;
    cmd_valid = cv;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_feat  = feat;
    dec_ready = drdy;
    res_valid = rv;
    res_id    = rid[11:0];
    res_class = rcls;
    #2;
    if (m_op == 2'b11) exp_ok = (m_pending.size() < TB_MAX_OUT);
    else               exp_ok = (m_pending.size() == 0) && !rv;
    exp_dv   = m_hold_v && exp_ok;
    exp_fire = exp_dv && drdy;
    exp_rdy  = !m_hold_v || exp_fire;
    checkOutput("cmd_ready", 64'(cmd_ready), 64'(exp_rdy));
    checkOutput("dec_valid", 64'(dec_valid), 64'(exp_dv));
    if (exp_dv) begin
      exp_data = (m_op == 2'b11) ? m_feat : {40'd0, 7'd0, m_addr[8], m_addr[7:0], m_wdata};
      checkOutput("dec_mode", 64'(dec_mode), 64'(m_op));
      checkOutput("dec_data", dec_data, exp_data);
      checkOutput("dec_id", 64'(dec_id), (m_op == 2'b11) ? 64'(m_next_id) : 64'd0);
    end
    checkOutput("busy", 64'(busy), 64'(m_hold_v || (m_pending.size() > 0)));
    checkOutput("err_timeout", 64'(err_timeout), 64'(m_err));
    checkOutput("cls_count", 64'(cls_count), 64'(m_cls));
    checkOutput("rslt_valid", 64'(rslt_valid), 64'(m_rv));
    if (m_rv) begin
      checkOutput("rslt_id", 64'(rslt_id), 64'(m_rid));
      checkOutput("rslt_class", 64'(rslt_class), 64'(m_rcls));
    end
    pre = m_pending.size();
    if (m_run >= TB_TIMEOUT) m_err = 1'b1;
    if (pre > 0 && !rv) m_run++;
    else                m_run = 0;
    if (rv && pre > 0) begin
      for (int i = 0; i < m_pending.size(); i++) begin
        if (m_pending[i] == rid) begin
          m_pending.delete(i);
          break;
        end
      end
    end
    if (exp_fire && m_op == 2'b11) begin
      m_pending.push_back(m_next_id);
      m_next_id = (m_next_id + 1) % 4096;
      m_cls     = (m_cls + 1) % 65536;
    end
    if (cv && exp_rdy) begin
      m_hold_v = 1'b1;
      m_op     = op;
      m_addr   = addr;
      m_wdata  = wdata;
      m_feat   = feat;
    end else if (exp_fire) begin
      m_hold_v = 1'b0;
    end
    m_rv   = rv;
    m_rid  = rid & 12'hFFF;
    m_rcls = rcls;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 2'b00, 9'h0, 8'h0, 64'h0, 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic retireOldest(input bit cls);
    applyStimulus(1'b0, 2'b00, 9'h0, 8'h0, 64'h0, 1'b1, 1'b1, m_pending[0], cls);
  endtask

  task automatic randomCycle(input int res_pct);
    bit          cv, drdy, rv, rcls;
    logic [1:0]  op;
    int          rid;
    cv   = ($urandom_range(0, 99) < 60);
    op   = 2'($urandom_range(0, 3));
    drdy = ($urandom_range(0, 99) < 75);
    rcls = 1'($urandom_range(0, 1));
    rv   = 1'b0;
    rid  = 0;
    if (m_pending.size() > 0 && $urandom_range(0, 99) < res_pct) begin
      rv  = 1'b1;
      rid = m_pending[$urandom_range(0, m_pending.size() - 1)];
    end else if (m_pending.size() == 0 && $urandom_range(0, 99) < 3) begin
      rv  = 1'b1;
      rid = int'($urandom_range(0, 4095));
    end
    applyStimulus(cv, op, 9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)),
                  {$urandom(), $urandom()}, drdy, rv, rid, rcls);
  endtask

  initial begin
    int guard;
    logic [63:0] f;
    $display("[TB] start");
    #1;
    doReset();

    // Table writes: feature-index then child write with address bit 8
    applyStimulus(1'b1, 2'b00, 9'h002, 8'h05, 64'h0, 1'b1, 1'b0, 0, 1'b0);
    idleCycle();
    applyStimulus(1'b1, 2'b10, 9'h105, 8'h07, 64'h0, 1'b1, 1'b0, 0, 1'b0);
    idleCycle();
    idleCycle();

    // Classify held under backpressure, then released
    f = {$urandom(), $urandom()};
    applyStimulus(1'b1, 2'b11, 9'h0, 8'h0, f, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 2'b11, 9'h0, 8'h0, {$urandom(), $urandom()}, 1'b0, 1'b0, 0, 1'b0);
    idleCycle();
    retireOldest(1'b1);
    applyStimulus(1'b1, 2'b11, 9'h0, 8'h0, {$urandom(), $urandom()}, 1'b1, 1'b0, 0, 1'b0);
    idleCycle();
    retireOldest(1'b0);
    idleCycle();

    // Fill to the in-flight limit, then free one slot
    doReset();
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 2'b11, 9'h0, 8'h0, {$urandom(), $urandom()}, 1'b1, 1'b0, 0, 1'b0);
    idleCycle();
    idleCycle();
    retireOldest(1'b1);
    idleCycle();
    guard = 0;
    while (m_pending.size() > 0 && guard < 64) begin
      retireOldest(1'($urandom_range(0, 1)));
      guard++;
    end
    idleCycle();

    // Threshold write behind an outstanding classify
    doReset();
    applyStimulus(1'b1, 2'b11, 9'h0, 8'h0, {$urandom(), $urandom()}, 1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 2'b01, 9'h033, 8'h44, 64'h0, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) idleCycle();
    retireOldest(1'b1);
    idleCycle();
    idleCycle();

    // Watchdog: one classify with no result
    doReset();
    applyStimulus(1'b1, 2'b11, 9'h0, 8'h0, {$urandom(), $urandom()}, 1'b1, 1'b0, 0, 1'b0);
    idleCycle();
    for (int i = 0; i < 7; i++) idleCycle();
    checkOutput("wd_before", 64'(err_timeout), 64'd0);
    idleCycle();
    checkOutput("wd_set", 64'(err_timeout), 64'd1);
    retireOldest(1'b0);
    idleCycle();
    idleCycle();
    checkOutput("wd_sticky", 64'(err_timeout), 64'd1);

    // Classify flood long enough to wrap the 12-bit ID
    doReset();
    guard = 0;
    while (m_cls < 4200 && guard < 20000) begin
      bit rv;
      int rid;
      rv  = (m_pending.size() > 0) && ($urandom_range(0, 99) < 90);
      rid = rv ? m_pending[$urandom_range(0, m_pending.size() - 1)] : 0;
      applyStimulus(1'b1, 2'b11, 9'h0, 8'h0, {$urandom(), $urandom()},
                    ($urandom_range(0, 99) < 95), rv, rid, 1'($urandom_range(0, 1)));
      guard++;
    end
    checkOutput("flood_done", 64'(m_cls >= 4200), 64'd1);

    // Random mixed traffic with a reset in the middle
    doReset();
    for (int i = 0; i < 1500; i++) randomCycle(40);
    doReset();
    for (int i = 0; i < 1500; i++) randomCycle(70);
    guard = 0;
    while (m_pending.size() > 0 && guard < 64) begin
      retireOldest(1'b0);
      guard++;
    end
    idleCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
